// File: rtl/id_scoreboard.sv
// id_scoreboard: per-register in-flight write counters for the ID stage.
// Holds ID on RAW or counter saturation; also keeps a sticky underflow flag and a stall counter.
module id_scoreboard #(
    parameter int NREG  = 32,
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            id_valid,
    input  logic            exe_allowin,
    input  logic [4:0]      id_rs1,
    input  logic            id_rs1_used,
    input  logic [4:0]      id_rs2,
    input  logic            id_rs2_used,
    input  logic            id_rf_we,
    input  logic [4:0]      id_rf_waddr,
    input  logic            wb_valid,
    input  logic            wb_rf_we,
    input  logic [4:0]      wb_rf_waddr,
    output logic            id_ready_go,
    output logic [NREG-1:0] busy_mask,
    output logic            sb_err,
    output logic [31:0]     stall_cycles
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [NREG-1:0]  ONE_HOT = {{(NREG-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic             err_q, err_d;
    logic [31:0]      stall_q, stall_d;
    logic             raw1, raw2, sat, issue, inc, dec;
    logic [NREG-1:0]  inc_hit, dec_hit;

    assign raw1        = id_rs1_used && id_rs1 != '0 && cnt_q[id_rs1] != '0;
    assign raw2        = id_rs2_used && id_rs2 != '0 && cnt_q[id_rs2] != '0;
    assign sat         = id_rf_we && id_rf_waddr != '0 && cnt_q[id_rf_waddr] == CNT_MAX;
    assign id_ready_go = !(raw1 || raw2 || sat);
    assign issue       = id_valid && id_ready_go && exe_allowin;
    assign inc         = issue && id_rf_we && id_rf_waddr != '0;
    assign dec         = wb_valid && wb_rf_we && wb_rf_waddr != '0;
    assign inc_hit     = inc ? ONE_HOT << id_rf_waddr : '0;
    assign dec_hit     = dec ? ONE_HOT << wb_rf_waddr : '0;

    // An issue and a retire on the same register cancel out; a retire at zero is held at zero.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 1; i < NREG; i++)
            cnt_d[i] = (inc_hit[i] && !dec_hit[i]) ? cnt_q[i] + 1'b1 :
                       (dec_hit[i] && !inc_hit[i] && cnt_q[i] != '0) ? cnt_q[i] - 1'b1 : cnt_q[i];
        err_d   = err_q || (dec && cnt_q[wb_rf_waddr] == '0);
        stall_d = stall_q + 32'(id_valid && !id_ready_go);
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 1; i < NREG; i++)
            busy_mask[i] = cnt_q[i] != '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREG; i++)
                cnt_q[i] <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            stall_q <= stall_d;
        end
    end

    assign sb_err       = err_q;
    assign stall_cycles = stall_q;
endmodule

// File: tb/tb_id_scoreboard.sv
// tb_id_scoreboard: directed scenarios for id_scoreboard with hand-computed expectations.
module tb_id_scoreboard;
    logic        clk = 1'b0;
    logic        resetn;
    logic        id_valid, exe_allowin;
    logic [4:0]  id_rs1, id_rs2, id_rf_waddr, wb_rf_waddr;
    logic        id_rs1_used, id_rs2_used, id_rf_we;
    logic        wb_valid, wb_rf_we;
    logic        id_ready_go;
    logic [31:0] busy_mask;
    logic        sb_err;
    logic [31:0] stall_cycles;
    int          total = 0;
    int          bad = 0;

    id_scoreboard dut (
        .clk(clk), .resetn(resetn), .id_valid(id_valid), .exe_allowin(exe_allowin),
        .id_rs1(id_rs1), .id_rs1_used(id_rs1_used), .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
        .id_rf_we(id_rf_we), .id_rf_waddr(id_rf_waddr), .wb_valid(wb_valid), .wb_rf_we(wb_rf_we),
        .wb_rf_waddr(wb_rf_waddr), .id_ready_go(id_ready_go), .busy_mask(busy_mask),
        .sb_err(sb_err), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic idle();
        id_valid = 0; exe_allowin = 1; id_rs1 = 0; id_rs1_used = 0; id_rs2 = 0; id_rs2_used = 0;
        id_rf_we = 0; id_rf_waddr = 0; wb_valid = 0; wb_rf_we = 0; wb_rf_waddr = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id_write(input logic [4:0] r);
        idle(); id_valid = 1; id_rf_we = 1; id_rf_waddr = r;
    endtask

    task automatic wb_retire(input logic [4:0] r);
        wb_valid = 1; wb_rf_we = 1; wb_rf_waddr = r;
    endtask

    task automatic test_reset();
        idle();
        resetn = 0;
        #3;
        total++; if (id_ready_go !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", id_ready_go); end
        total++; if (busy_mask !== 32'h0) begin bad++; $display("FAIL reset_busy got=%h want=0", busy_mask); end
        total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", sb_err); end
        total++; if (stall_cycles !== 32'd0) begin bad++; $display("FAIL reset_stall got=%0d want=0", stall_cycles); end
        tick(); tick();
        resetn = 1;
        tick();
    endtask

    task automatic test_idle();
        idle(); id_valid = 1; id_rs1 = 5; id_rs1_used = 1;
        for (int c = 0; c < 4; c++) begin
            #1;
            total++; if (id_ready_go !== 1'b1) begin bad++; $display("FAIL idle_ready c=%0d got=%b want=1", c, id_ready_go); end
            tick();
        end
        total++; if (stall_cycles !== 32'd0) begin bad++; $display("FAIL idle_stall got=%0d want=0", stall_cycles); end
        total++; if (busy_mask !== 32'h0) begin bad++; $display("FAIL idle_busy got=%h want=0", busy_mask); end
        idle();
    endtask

    task automatic test_raw();
        id_write(3); #1;
        total++; if (id_ready_go !== 1'b1) begin bad++; $display("FAIL raw_c0_ready got=%b want=1", id_ready_go); end
        tick();
        idle(); id_valid = 1; id_rs2 = 3; id_rs2_used = 1;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) wb_retire(3);
            #1;
            total++; if (id_ready_go !== 1'b0) begin bad++; $display("FAIL raw_stall c=%0d got=%b want=0", c, id_ready_go); end
            total++; if (busy_mask !== 32'h8) begin bad++; $display("FAIL raw_busy c=%0d got=%h want=8", c, busy_mask); end
            tick();
        end
        wb_valid = 0; #1;
        total++; if (id_ready_go !== 1'b1) begin bad++; $display("FAIL raw_c4_ready got=%b want=1", id_ready_go); end
        total++; if (stall_cycles !== 32'd3) begin bad++; $display("FAIL raw_stall_cnt got=%0d want=3", stall_cycles); end
        total++; if (busy_mask !== 32'h0) begin bad++; $display("FAIL raw_c4_busy got=%h want=0", busy_mask); end
        id_valid = 0;
        tick();
    endtask

    task automatic test_waw_sat();
        for (int k = 0; k < 3; k++) begin
            id_write(7); #1;
            total++; if (id_ready_go !== 1'b1) begin bad++; $display("FAIL waw_issue k=%0d got=%b want=1", k, id_ready_go); end
            tick();
        end
        #1;
        total++; if (id_ready_go !== 1'b0) begin bad++; $display("FAIL waw_sat got=%b want=0", id_ready_go); end
        total++; if (busy_mask !== 32'h80) begin bad++; $display("FAIL waw_busy got=%h want=80", busy_mask); end
        tick();
        wb_retire(7); #1;
        total++; if (id_ready_go !== 1'b0) begin bad++; $display("FAIL waw_sat_retire got=%b want=0", id_ready_go); end
        tick();
        wb_valid = 0; #1;
        total++; if (id_ready_go !== 1'b1) begin bad++; $display("FAIL waw_after_retire got=%b want=1", id_ready_go); end
        tick();
        #1;
        total++; if (id_ready_go !== 1'b0) begin bad++; $display("FAIL waw_resat got=%b want=0", id_ready_go); end
        total++; if (stall_cycles !== 32'd5) begin bad++; $display("FAIL waw_stall_cnt got=%0d want=5", stall_cycles); end
        idle();
        for (int k = 0; k < 3; k++) begin
            wb_retire(7);
            tick();
        end
        wb_valid = 0;
        total++; if (busy_mask !== 32'h0) begin bad++; $display("FAIL waw_drain_busy got=%h want=0", busy_mask); end
        total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL waw_drain_err got=%b want=0", sb_err); end
    endtask

    task automatic test_inc_dec();
        id_write(9); tick();
        id_write(9); wb_retire(9); #1;
        total++; if (id_ready_go !== 1'b1) begin bad++; $display("FAIL incdec_ready got=%b want=1", id_ready_go); end
        tick();
        total++; if (busy_mask !== 32'h200) begin bad++; $display("FAIL incdec_same_busy got=%h want=200", busy_mask); end
        id_write(4); wb_retire(9); tick();
        total++; if (busy_mask !== 32'h10) begin bad++; $display("FAIL incdec_diff_busy got=%h want=10", busy_mask); end
        idle(); wb_retire(4); tick();
        idle();
        total++; if (busy_mask !== 32'h0) begin bad++; $display("FAIL incdec_drain_busy got=%h want=0", busy_mask); end
        total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL incdec_err got=%b want=0", sb_err); end
    endtask

    task automatic test_r0_underflow();
        id_write(0); id_rs1 = 0; id_rs1_used = 1; id_rs2 = 0; id_rs2_used = 1; #1;
        total++; if (id_ready_go !== 1'b1) begin bad++; $display("FAIL r0_ready got=%b want=1", id_ready_go); end
        tick();
        total++; if (busy_mask !== 32'h0) begin bad++; $display("FAIL r0_busy got=%h want=0", busy_mask); end
        idle(); wb_retire(12); tick();
        idle();
        total++; if (sb_err !== 1'b1) begin bad++; $display("FAIL uf_err got=%b want=1", sb_err); end
        total++; if (busy_mask !== 32'h0) begin bad++; $display("FAIL uf_busy got=%h want=0", busy_mask); end
        id_write(12); tick();
        total++; if (busy_mask !== 32'h1000) begin bad++; $display("FAIL uf_cnt12 got=%h want=1000", busy_mask); end
        idle(); wb_retire(12); tick();
        idle(); tick(); tick();
        total++; if (busy_mask !== 32'h0) begin bad++; $display("FAIL uf_cnt12_drain got=%h want=0", busy_mask); end
        total++; if (sb_err !== 1'b1) begin bad++; $display("FAIL uf_sticky got=%b want=1", sb_err); end
        total++; if (stall_cycles !== 32'd5) begin bad++; $display("FAIL uf_stall_cnt got=%0d want=5", stall_cycles); end
    endtask

    task automatic test_async_reset();
        id_write(3); tick();
        id_write(7); tick();
        idle(); id_valid = 1; id_rs1 = 3; id_rs1_used = 1;
        for (int c = 0; c < 12; c++) tick();
        total++; if (busy_mask !== 32'h88) begin bad++; $display("FAIL ar_pre_busy got=%h want=88", busy_mask); end
        total++; if (stall_cycles !== 32'd17) begin bad++; $display("FAIL ar_pre_stall got=%0d want=17", stall_cycles); end
        total++; if (id_ready_go !== 1'b0) begin bad++; $display("FAIL ar_pre_ready got=%b want=0", id_ready_go); end
        #2;
        resetn = 0;
        #1;
        total++; if (id_ready_go !== 1'b1) begin bad++; $display("FAIL ar_ready got=%b want=1", id_ready_go); end
        total++; if (busy_mask !== 32'h0) begin bad++; $display("FAIL ar_busy got=%h want=0", busy_mask); end
        total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL ar_err got=%b want=0", sb_err); end
        total++; if (stall_cycles !== 32'd0) begin bad++; $display("FAIL ar_stall got=%0d want=0", stall_cycles); end
        tick();
        resetn = 1;
        idle(); tick();
        total++; if (busy_mask !== 32'h0 || stall_cycles !== 32'd0) begin bad++; $display("FAIL ar_post got=%h/%0d want=0/0", busy_mask, stall_cycles); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_raw();
        test_waw_sat();
        test_inc_dec();
        test_r0_underflow();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
